// File: rtl/logic_bitop_seq_pkg.sv
// Shared definitions for the sequential bitwise logic unit: opcode and state
// encodings plus the single-bit logic function applied across each slice.
package logic_bitop_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic bit_op(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_bitop_seq_if.sv
// Request/response bundle of the sequential logic unit: operand request on the
// input side and result/ZERO flag on the output side, each with valid/ready.
interface logic_bitop_seq_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, busy
    );

endinterface

// File: rtl/logic_bitop_seq_slice.sv
// Combinational slice function: applies the selected bitwise operation to one
// SLICE-bit chunk of the operands. No cross-bit dependence exists.
module logic_bitop_seq_slice
    import logic_bitop_seq_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Per-bit logic function across the slice
    always_comb begin
        y = '0;
        for (int i = 0; i < SLICE; i++) begin
            y[i] = bit_op(op, a[i], b[i]);
        end
    end

endmodule

// File: rtl/logic_bitop_seq.sv
// Multi-cycle bitwise logic unit: operands are consumed SLICE bits per cycle,
// LSB first, and the result is assembled MSB-inward in a shift register.
module logic_bitop_seq
    import logic_bitop_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_bitop_seq_if.slave bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_r, state_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] y_r, y_s;
    logic [1:0]       op_r, op_s;
    logic [SLICE-1:0] slice_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             zero_r;

    logic_bitop_seq_slice #(.SLICE(SLICE)) u_slice (
        .op (op_r),
        .a  (a_r[SLICE-1:0]),
        .b  (b_r[SLICE-1:0]),
        .y  (slice_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        a_s     = a_r;
        b_s     = b_r;
        y_s     = y_r;
        op_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_s     = bus.a;
                    b_s     = bus.b;
                    op_s    = bus.op;
                    y_s     = '0;
                    count_s = '0;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // New slice enters at the top; shifts are written so SLICE==WIDTH stays legal
                y_s     = (y_r >> SLICE) | (WIDTH'(slice_s) << (WIDTH - SLICE));
                a_s     = a_r >> SLICE;
                b_s     = b_r >> SLICE;
                count_s = count_r + CW'(1);
                if (count_r == LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            a_r         <= '0;
            b_r         <= '0;
            y_r         <= '0;
            op_r        <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            zero_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            a_r         <= a_s;
            b_r         <= b_s;
            y_r         <= y_s;
            op_r        <= op_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            zero_r      <= ~|y_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.y         = y_r;
    assign bus.zero      = zero_r;

endmodule
